// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer:
// CP0 op encodings, sequencer states, vector defaults and the control decode.
package int_seq_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NUM_W  = 2;
  localparam int unsigned OP_W   = 2;

  localparam logic [ADDR_W-1:0] VEC_BASE_DEF   = 32'h0000_0800;
  localparam logic [ADDR_W-1:0] VEC_STRIDE_DEF = 32'h0000_0020;

  typedef enum logic [OP_W-1:0] {
    CP0_OP_NONE = 2'd0,
    CP0_OP_IRQ  = 2'd1,
    CP0_OP_RET  = 2'd2
  } cp0_op_e;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_ENTRY  = 3'd1,
    SEQ_VECTOR = 3'd2,
    SEQ_RET    = 3'd3,
    SEQ_RESUME = 3'd4
  } seq_state_e;

  typedef struct packed {
    cp0_op_e op;
    logic    w_en_epc;
    logic    cpu_hold;
    logic    pc_redirect;
  } seq_ctl_t;

  // Single-bit control outputs as a pure function of the sequencer state.
  function automatic seq_ctl_t decode_ctl(input seq_state_e s);
    seq_ctl_t c;
    c = '{op: CP0_OP_NONE, w_en_epc: 1'b0, cpu_hold: 1'b0, pc_redirect: 1'b0};
    case (s)
      SEQ_ENTRY: begin
        c.op       = CP0_OP_IRQ;
        c.w_en_epc = 1'b1;
        c.cpu_hold = 1'b1;
      end
      SEQ_VECTOR: begin
        c.pc_redirect = 1'b1;
        c.cpu_hold    = 1'b1;
      end
      SEQ_RET: begin
        c.op       = CP0_OP_RET;
        c.cpu_hold = 1'b1;
      end
      SEQ_RESUME: begin
        c.pc_redirect = 1'b1;
        c.cpu_hold    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/int_vec_calc.sv
// Combinational per-source handler vector: base + num * stride, modulo 2^32.
module int_vec_calc
  import int_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic [NUM_W-1:0]  num,
  output logic [ADDR_W-1:0] addr_c
);

  logic [ADDR_W-1:0] offset;

  assign offset = ADDR_W'(num) * VEC_STRIDE;
  assign addr_c = VEC_BASE + offset;

endmodule

// File: rtl/int_seq.sv
// Interrupt entry/return sequencer driving the CP0 control inputs and PC redirect.
// Optional atomic IE save/disable/restore when INT_SEQ_ATOMIC_IE_EN is defined.
// The CP0 "int" signal is named int_in here because "int" is a reserved word.
module int_seq
  import int_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              int_in,
  input  logic [NUM_W-1:0]  int_num,
  input  logic [ADDR_W-1:0] epc,
`ifdef INT_SEQ_ATOMIC_IE_EN
  input  logic [ADDR_W-1:0] ie,
`endif
  input  logic              instr_done,
  input  logic              is_eret,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [OP_W-1:0]   op_cp0,
  output logic              w_en_epc,
  output logic [ADDR_W-1:0] epc_w_data,
  output logic              w_en_ie,
  output logic [ADDR_W-1:0] ie_w_data,
  output logic              cpu_hold,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_addr
);

  seq_state_e        state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  seq_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] epc_w_data_q, epc_w_data_d;
  logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
  logic [ADDR_W-1:0] vec_addr_c;

  int_vec_calc #(
    .VEC_BASE  (VEC_BASE),
    .VEC_STRIDE(VEC_STRIDE)
  ) u_vec (
    .num   (num_q),
    .addr_c(vec_addr_c)
  );

  // Next state plus entry-time latches; outputs are the decode of the next
  // state so the registered outputs always match the registered state.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pc_d    = pc_q;
    case (state_q)
      SEQ_IDLE: begin
        if (instr_done && is_eret) begin
          state_d = SEQ_RET;
        end else if (instr_done && int_in) begin
          state_d = SEQ_ENTRY;
          num_d   = int_num;
          pc_d    = pc_next;
        end
      end
      SEQ_ENTRY:  state_d = SEQ_VECTOR;
      SEQ_VECTOR: state_d = SEQ_IDLE;
      SEQ_RET:    state_d = SEQ_RESUME;
      SEQ_RESUME: state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase

    ctl_d           = decode_ctl(state_d);
    epc_w_data_d    = (state_d == SEQ_ENTRY) ? pc_d : '0;
    redirect_addr_d = (state_d == SEQ_VECTOR) ? vec_addr_c : '0;
  end

  // en=0 freezes state and outputs so a pending CP0 op is not re-issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= SEQ_IDLE;
      num_q           <= '0;
      pc_q            <= '0;
      ctl_q           <= '{op: CP0_OP_NONE, w_en_epc: 1'b0, cpu_hold: 1'b0, pc_redirect: 1'b0};
      epc_w_data_q    <= '0;
      redirect_addr_q <= '0;
    end else if (en) begin
      state_q         <= state_d;
      num_q           <= num_d;
      pc_q            <= pc_d;
      ctl_q           <= ctl_d;
      epc_w_data_q    <= epc_w_data_d;
      redirect_addr_q <= redirect_addr_d;
    end
  end

`ifdef INT_SEQ_ATOMIC_IE_EN
  logic [ADDR_W-1:0] ie_saved_q, ie_saved_d;
  logic              w_en_ie_q, w_en_ie_d;
  logic [ADDR_W-1:0] ie_w_data_q, ie_w_data_d;

  // Capture IE on entry, write it back with global enable cleared; restore on return.
  always_comb begin
    ie_saved_d  = ie_saved_q;
    w_en_ie_d   = 1'b0;
    ie_w_data_d = '0;
    if (state_q == SEQ_IDLE && state_d == SEQ_ENTRY) begin
      ie_saved_d = ie;
    end
    if (state_d == SEQ_ENTRY) begin
      w_en_ie_d   = 1'b1;
      ie_w_data_d = {ie_saved_d[ADDR_W-1:1], 1'b0};
    end else if (state_d == SEQ_RET) begin
      w_en_ie_d   = 1'b1;
      ie_w_data_d = ie_saved_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_saved_q  <= 32'h1;
      w_en_ie_q   <= 1'b0;
      ie_w_data_q <= '0;
    end else if (en) begin
      ie_saved_q  <= ie_saved_d;
      w_en_ie_q   <= w_en_ie_d;
      ie_w_data_q <= ie_w_data_d;
    end
  end

  assign w_en_ie   = w_en_ie_q;
  assign ie_w_data = ie_w_data_q;
`else
  assign w_en_ie   = 1'b0;
  assign ie_w_data = '0;
`endif

  assign op_cp0      = ctl_q.op;
  assign w_en_epc    = ctl_q.w_en_epc;
  assign cpu_hold    = ctl_q.cpu_hold;
  assign pc_redirect = ctl_q.pc_redirect;
  assign epc_w_data  = epc_w_data_q;

  // Return target follows the live EPC during RESUME.
  assign redirect_addr = (state_q == SEQ_RESUME) ? epc : redirect_addr_q;

endmodule

// File: tb/tb_int_seq.sv
// Scoreboard bench for int_seq: expected output sets are queued as stimulus
// is driven and compared against the DUT each cycle.
module tb_int_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        int_in;
  logic [1:0]  int_num;
  logic [31:0] epc;
  logic        instr_done;
  logic        is_eret;
  logic [31:0] pc_next;
  logic [1:0]  op_cp0;
  logic        w_en_epc;
  logic [31:0] epc_w_data;
  logic        w_en_ie;
  logic [31:0] ie_w_data;
  logic        cpu_hold;
  logic        pc_redirect;
  logic [31:0] redirect_addr;
`ifdef INT_SEQ_ATOMIC_IE_EN
  logic [31:0] ie = 32'h1;
  localparam logic        IE_W     = 1'b1;
  localparam logic [31:0] IE_RET_D = 32'h1;
`else
  localparam logic        IE_W     = 1'b0;
  localparam logic [31:0] IE_RET_D = 32'h0;
`endif

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_IRQ  = 2'd1;
  localparam logic [1:0] OP_RET  = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic        wepc;
    logic [31:0] epcd;
    logic        hold;
    logic        redir;
    logic [31:0] addr;
    logic        wie;
    logic [31:0] ied;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .int_in       (int_in),
    .int_num      (int_num),
    .epc          (epc),
`ifdef INT_SEQ_ATOMIC_IE_EN
    .ie           (ie),
`endif
    .instr_done   (instr_done),
    .is_eret      (is_eret),
    .pc_next      (pc_next),
    .op_cp0       (op_cp0),
    .w_en_epc     (w_en_epc),
    .epc_w_data   (epc_w_data),
    .w_en_ie      (w_en_ie),
    .ie_w_data    (ie_w_data),
    .cpu_hold     (cpu_hold),
    .pc_redirect  (pc_redirect),
    .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t e_idle();
    return '{OP_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
  endfunction
  function automatic exp_t e_entry(input logic [31:0] pc);
    return '{OP_IRQ, 1'b1, pc, 1'b1, 1'b0, 32'h0, IE_W, 32'h0};
  endfunction
  function automatic exp_t e_vector(input logic [1:0] num);
    logic [31:0] a;
    a = 32'h0000_0800 + {30'd0, num} * 32'h0000_0020;
    return '{OP_NONE, 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b0, 32'h0};
  endfunction
  function automatic exp_t e_ret();
    return '{OP_RET, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, IE_W, IE_RET_D};
  endfunction
  function automatic exp_t e_resume(input logic [31:0] a);
    return '{OP_NONE, 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b0, 32'h0};
  endfunction

  task automatic compare_now(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".op"},    32'(op_cp0),      32'(e.op));
    check({tag, ".wepc"},  32'(w_en_epc),    32'(e.wepc));
    check({tag, ".epcd"},  epc_w_data,       e.epcd);
    check({tag, ".hold"},  32'(cpu_hold),    32'(e.hold));
    check({tag, ".redir"}, 32'(pc_redirect), 32'(e.redir));
    check({tag, ".addr"},  redirect_addr,    e.addr);
    check({tag, ".wie"},   32'(w_en_ie),     32'(e.wie));
    check({tag, ".ied"},   ie_w_data,        e.ied);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #2;
    compare_now(tag);
  endtask

  task automatic do_entry(input logic [1:0] num, input logic [31:0] pc);
    int_in = 1'b1; int_num = num; instr_done = 1'b1; pc_next = pc;
    sb.push_back(e_entry(pc));
    cyc("entry");
    int_in = 1'b0; instr_done = 1'b0;
    sb.push_back(e_vector(num));
    cyc("vector");
    sb.push_back(e_idle());
    cyc("post_vec");
  endtask

  task automatic do_eret(input logic [31:0] epc_v);
    epc = epc_v; instr_done = 1'b1; is_eret = 1'b1;
    sb.push_back(e_ret());
    cyc("ret");
    instr_done = 1'b0; is_eret = 1'b0;
    sb.push_back(e_resume(epc_v));
    cyc("resume");
    sb.push_back(e_idle());
    cyc("post_ret");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; int_in = 1'b0; int_num = 2'd0; epc = 32'h0;
    instr_done = 1'b0; is_eret = 1'b0; pc_next = 32'h0;
    #1;
    sb.push_back(e_idle());
    compare_now("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(e_idle());
    cyc("idle0");

    // int without a boundary must not start a sequence
    int_in = 1'b1; int_num = 2'd1;
    sb.push_back(e_idle());
    cyc("int_no_done");
    int_in = 1'b0;

    do_entry(2'd2, 32'h0000_0104);
    do_eret(32'h0000_0104);

    // Return target tracks the live EPC during RESUME
    epc = 32'h0000_0104; instr_done = 1'b1; is_eret = 1'b1;
    sb.push_back(e_ret());
    cyc("ret2");
    instr_done = 1'b0; is_eret = 1'b0;
    sb.push_back(e_resume(32'h0000_0104));
    cyc("resume2");
    epc = 32'h0000_0300;
    #1;
    sb.push_back(e_resume(32'h0000_0300));
    compare_now("resume_live_epc");
    sb.push_back(e_idle());
    cyc("post_ret2");

    // ERET and int together: return first, entry at the next boundary
    epc = 32'h0000_0200; instr_done = 1'b1; is_eret = 1'b1;
    int_in = 1'b1; int_num = 2'd1; pc_next = 32'h0000_0500;
    sb.push_back(e_ret());
    cyc("sim_ret");
    instr_done = 1'b0; is_eret = 1'b0;
    sb.push_back(e_resume(32'h0000_0200));
    cyc("sim_resume");
    sb.push_back(e_idle());
    cyc("sim_idle");
    do_entry(2'd1, 32'h0000_0600);

    // Inputs outside IDLE are ignored
    int_in = 1'b1; int_num = 2'd0; instr_done = 1'b1; pc_next = 32'h0000_0010;
    sb.push_back(e_entry(32'h0000_0010));
    cyc("ign_entry");
    is_eret = 1'b1; int_num = 2'd3; pc_next = 32'h0000_0abc;
    sb.push_back(e_vector(2'd0));
    cyc("ign_vector");
    instr_done = 1'b0; is_eret = 1'b0; int_in = 1'b0;
    sb.push_back(e_idle());
    cyc("ign_idle");

    // Stall in ENTRY holds the CP0 op for every stalled cycle
    int_in = 1'b1; int_num = 2'd3; instr_done = 1'b1; pc_next = 32'h0000_0700;
    sb.push_back(e_entry(32'h0000_0700));
    cyc("stall_entry");
    int_in = 1'b0; instr_done = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(e_entry(32'h0000_0700));
      cyc("stall_hold");
    end
    en = 1'b1;
    sb.push_back(e_vector(2'd3));
    cyc("stall_vector");
    sb.push_back(e_idle());
    cyc("stall_idle");

    // Reset in VECTOR aborts at once with no later redirect
    int_in = 1'b1; int_num = 2'd2; instr_done = 1'b1; pc_next = 32'h0000_0900;
    sb.push_back(e_entry(32'h0000_0900));
    cyc("rst_entry");
    int_in = 1'b0; instr_done = 1'b0;
    sb.push_back(e_vector(2'd2));
    cyc("rst_vector");
    rst_n = 1'b0;
    #1;
    sb.push_back(e_idle());
    compare_now("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(e_idle());
      cyc("rst_after");
    end

    // Every source index, including the top one, with random resume PCs
    for (int n = 0; n < 4; n++) begin
      do_entry(2'(n), {$urandom_range(0, 32'h00ff_ffff), 2'b00} & 32'hffff_fffc);
      do_eret(32'h0000_1000 + 32'(n) * 32'h10);
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
- Core-side interrupt entry/return sequencer; the initiator on the CP0 interrupt interface.
- Consumes the CP0 `int` and `int_num` outputs at instruction boundaries.
- Drives the CP0 control inputs: `op_cp0`, EPC write, IE write.
- Redirects the PC to the per-source handler vector on entry, and back to EPC on ERET.

Parameters:
- VEC_BASE, 32'h0000_0800, handler vector address for source 0.
- VEC_STRIDE, 32'h0000_0020, address spacing between per-source handler vectors.

Ports:
- clk  in  1  core clock; state updates on posedge so outputs are stable before the CP0 negedge sample.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global stall-release; when 0, state and all outputs hold.
- int  in  1  pending-and-enabled interrupt from CP0.
- int_num  in  2  index of the highest-priority deliverable source, from CP0.
- epc  in  32  current EPC from CP0.
- instr_done  in  1  an instruction retires this cycle (interrupt boundary).
- is_eret  in  1  the retiring instruction is ERET (valid only with instr_done).
- pc_next  in  32  resume address of the retiring instruction.
- op_cp0  out  2  CP0 operation: CP0_OP_NONE, CP0_OP_IRQ or CP0_OP_RET.
- w_en_epc  out  1  EPC write enable.
- epc_w_data  out  32  EPC write data.
- w_en_ie  out  1  IE write enable; tied 0 unless the optional feature is enabled.
- ie_w_data  out  32  IE write data.
- cpu_hold  out  1  freeze fetch/issue.
- pc_redirect  out  1  load `redirect_addr` into PC this cycle.
- redirect_addr  out  32  PC redirect target.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; all outputs 0; op_cp0=CP0_OP_NONE.
  - Latched num=0, latched pc=0.
  - Reset mid-sequence aborts immediately, with no partial CP0 op.
- Moore outputs, decoded from the registered state only.
- IDLE: all outputs inactive.
  - instr_done&&is_eret -> RET.
  - Else instr_done&&int -> ENTRY; at this posedge latch int_num->num and pc_next->pc.
  - Simultaneous ERET and int: ERET wins; int is re-evaluated in IDLE after the return completes.
  - int without instr_done: stay in IDLE, no action.
- ENTRY (1 cycle):
  - op_cp0=CP0_OP_IRQ, w_en_epc=1, epc_w_data=pc, cpu_hold=1.
  - Next state: VECTOR.
- VECTOR (1 cycle):
  - pc_redirect=1, redirect_addr=VEC_BASE+num*VEC_STRIDE (32-bit, wraps modulo 2^32), cpu_hold=1.
  - Next state: IDLE.
- RET (1 cycle):
  - op_cp0=CP0_OP_RET, cpu_hold=1.
  - Next state: RESUME.
- RESUME (1 cycle):
  - pc_redirect=1, redirect_addr=epc (sampled combinationally in this cycle), cpu_hold=1.
  - Next state: IDLE.
- Latency:
  - int to redirect: 2 cycles after the boundary cycle.
  - ERET to redirect: 2 cycles.
- Inputs are ignored outside IDLE.
- en=0 freezes the FSM and holds outputs, so a CP0 op stays asserted and CP0 (also gated by en) does not double-apply it.
- Nesting:
  - EPC is overwritten on every entry; handlers save and restore EPC in software before re-enabling nested delivery.
  - Priority masking is CP0's responsibility.
- Illegal state encodings -> IDLE.

Optional Feature:
- Macro: INT_SEQ_ATOMIC_IE_EN.
- Defined:
  - ENTRY also asserts w_en_ie=1 with ie_w_data = {ie_saved[31:1],1'b0} (global disable).
  - RET asserts w_en_ie=1 restoring the IE value captured at entry.
  - Adds a 32-bit `ie` input and a saved-IE register (reset 32'h1).
- Undefined:
  - w_en_ie=0 and ie_w_data=0 constantly; no `ie` port.
  - Nesting is governed solely by CP0 masking.

Decomposition:
- Shared header Core.vh holds:
  - CP0_OP_NONE/CP0_OP_IRQ/CP0_OP_RET encodings.
  - Sequencer state encodings SEQ_IDLE, SEQ_ENTRY, SEQ_VECTOR, SEQ_RET, SEQ_RESUME.
  - VEC_BASE/VEC_STRIDE defaults.
- Optional sub-module int_vec_calc: combinational vector address generator. Otherwise a single module.

Test Plan:
- Entry from IDLE:
  - Stimulus: int=1, int_num=2, instr_done=1, pc_next=32'h0000_0104.
  - Next cycle: op_cp0=IRQ, w_en_epc=1, epc_w_data=32'h0000_0104.
  - Following cycle: pc_redirect=1, redirect_addr=32'h0000_0840.
- Return:
  - Stimulus: instr_done=1, is_eret=1, epc=32'h0000_0104.
  - Next cycle: op_cp0=RET.
  - Following cycle: pc_redirect=1, redirect_addr=32'h0000_0104; then IDLE.
- Simultaneous events:
  - Stimulus: instr_done=1, is_eret=1, int=1.
  - RET/RESUME sequence runs; ENTRY starts at the next boundary with int still high.
- Stall:
  - Stimulus: en=0 for 3 cycles while in ENTRY.
  - op_cp0 stays IRQ and w_en_epc stays 1 for all 3 cycles; VECTOR follows one cycle after en=1.
- Reset mid-operation:
  - Stimulus: rst_n=0 in VECTOR.
  - All outputs 0 immediately; IDLE after release; no redirect issued.
- Optional feature (INT_SEQ_ATOMIC_IE_EN, ie=32'h1):
  - ENTRY writes ie_w_data=32'h0.
  - RET writes ie_w_data=32'h1.
